// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Row and column codes are active-low one-cold throughout.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } statetype;

    localparam logic [3:0] ROW_NONE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // True when exactly one of the four bits is low.
    function automatic logic onehot_low(input logic [3:0] code);
        logic [2:0] zeros;
        zeros = 3'd0;
        for (int i = 0; i < 4; i++) begin
            zeros = zeros + {2'b00, ~code[i]};
        end
        return (zeros == 3'd1);
    endfunction

    // Advance the driven column: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] next_col(input logic [3:0] code);
        return {code[2:0], code[3]};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones.
// Output lags the input by two clk cycles.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad one column at a time, debounces press and release,
// and reports each accepted press as a one-cycle key_valid with one-cold row/column codes.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    statetype        state;
    statetype        state_next;
    logic [3:0]      row_s;
    logic [SW-1:0]   dwell;
    logic [SW-1:0]   dwell_next;
    logic [DW-1:0]   deb_cnt;
    logic [DW-1:0]   deb_cnt_next;
    logic [3:0]      cand_row;
    logic [3:0]      cand_row_next;
    logic [3:0]      cand_col;
    logic [3:0]      cand_col_next;
    logic [3:0]      col_n_next;
    logic [3:0]      key_row_next;
    logic [3:0]      key_col_next;
    logic            key_valid_next;
    logic            key_held_next;
    logic            sample_now;
    logic            single_row;
    logic            cand_match;
    logic            deb_done;
    logic            key_down;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_s)
    );

    assign sample_now = (dwell == DWELL_LAST);
    assign single_row = onehot_low(row_s);
    assign cand_match = (row_s == cand_row);
    assign deb_done   = (deb_cnt == DEB_LAST);
    // Once a key is accepted only its own row bit matters; other keys are ignored.
    assign key_down   = |(~key_row & ~row_s);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SCAN: begin
                if (sample_now && single_row) begin
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!cand_match) begin
                    state_next = SCAN;
                end else if (deb_done) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (!key_down) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (key_down) begin
                    state_next = PRESSED;
                end else if (deb_done) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        dwell_next     = dwell;
        deb_cnt_next   = deb_cnt;
        cand_row_next  = cand_row;
        cand_col_next  = cand_col;
        col_n_next     = col_n;
        key_row_next   = key_row;
        key_col_next   = key_col;
        key_valid_next = 1'b0;
        key_held_next  = key_held;
        unique case (state)
            SCAN: begin
                // Rows are only looked at on the last dwell cycle so the
                // synchronizer has flushed the previous column's rows.
                if (sample_now) begin
                    dwell_next = '0;
                    if (single_row) begin
                        cand_row_next = row_s;
                        cand_col_next = col_n;
                        deb_cnt_next  = '0;
                    end else begin
                        col_n_next = next_col(col_n);
                    end
                end else begin
                    dwell_next = dwell + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (!cand_match) begin
                    deb_cnt_next = '0;
                    col_n_next   = next_col(col_n);
                end else if (deb_done) begin
                    deb_cnt_next   = '0;
                    key_valid_next = 1'b1;
                    key_row_next   = cand_row;
                    key_col_next   = cand_col;
                    key_held_next  = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + DW'(1);
                end
            end
            PRESSED: begin
                deb_cnt_next = '0;
            end
            RELEASE: begin
                if (key_down) begin
                    deb_cnt_next = '0;
                end else if (deb_done) begin
                    deb_cnt_next  = '0;
                    key_held_next = 1'b0;
                    col_n_next    = next_col(col_n);
                end else begin
                    deb_cnt_next = deb_cnt + DW'(1);
                end
            end
            default: begin
                deb_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dwell     <= '0;
            deb_cnt   <= '0;
            cand_row  <= ROW_NONE;
            cand_col  <= COL_FIRST;
            col_n     <= COL_FIRST;
            key_row   <= ROW_NONE;
            key_col   <= ROW_NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            dwell     <= dwell_next;
            deb_cnt   <= deb_cnt_next;
            cand_row  <= cand_row_next;
            cand_col  <= cand_col_next;
            col_n     <= col_n_next;
            key_row   <= key_row_next;
            key_col   <= key_col_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

endmodule
